cpuori_oci_dct_packer: RTL

Data-trace compression packer for the cpuori on-chip instrumentation (OCI) path.
- Collects 2-bit trace atoms from the trace-control stage into a 30-bit shift buffer holding up to 15 atoms.
- Exports the live dct_buffer/dct_count pair to the OCI test bench.
- Emits packed 36-bit trace frames to the trace FIFO through a single-entry valid/ready output register.

---
 rtl/cpuori_oci_pkg.sv | 28 ++
 rtl/cpuori_oci_dct_outreg.sv | 36 +++
 rtl/cpuori_oci_dct_packer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/cpuori_oci_pkg.sv
// Shared constants and helpers for the cpuori OCI trace path.
// Frame layout: {count, pad, buffer}.
package cpuori_oci_pkg;

    localparam int DCT_ATOM_W  = 2;
    localparam int DCT_DEPTH   = 15;
    localparam int DCT_CNT_W   = 4;
    localparam int DCT_BUF_W   = DCT_ATOM_W * DCT_DEPTH;
    localparam int DCT_FRAME_W = 36;
    localparam int DCT_PAD_W   = DCT_FRAME_W - DCT_CNT_W - DCT_BUF_W;

    localparam logic [DCT_CNT_W-1:0] DCT_CNT_FULL = DCT_CNT_W'(DCT_DEPTH);
    localparam logic [DCT_CNT_W-1:0] DCT_CNT_LAST = DCT_CNT_W'(DCT_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FILL  = 2'd1,
        ST_FULL  = 2'd2
    } dct_state_e;

    function automatic logic [DCT_FRAME_W-1:0] pack_dct_frame(
        input logic [DCT_CNT_W-1:0] count,
        input logic [DCT_BUF_W-1:0] buffer
    );
        return {count, {DCT_PAD_W{1'b0}}, buffer};
    endfunction

endpackage

// File: rtl/cpuori_oci_dct_outreg.sv
// Single-entry valid/ready output register for trace frames.
// A load while the entry drains replaces it with no bubble.
module cpuori_oci_dct_outreg
    import cpuori_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   i_load,
    input  logic [DCT_FRAME_W-1:0] i_data,
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic [DCT_FRAME_W-1:0] o_data,
    output logic                   o_slot_free
);

    logic                   r_valid;
    logic [DCT_FRAME_W-1:0] r_data;

    assign o_valid     = r_valid;
    assign o_data      = r_data;
    assign o_slot_free = !r_valid || i_ready;

    // Capture a new frame, or retire the held one once accepted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/cpuori_oci_dct_packer.sv
// Data-trace packer: gathers 2-bit atoms into 15-atom frames.
// Frames leave through a single-entry valid/ready register.
module cpuori_oci_dct_packer
    import cpuori_oci_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   trc_on,
    input  logic                   atom_valid,
    input  logic [DCT_ATOM_W-1:0]  atom,
    input  logic                   flush,
    output logic [DCT_BUF_W-1:0]   dct_buffer,
    output logic [DCT_CNT_W-1:0]   dct_count,
    output logic                   frame_valid,
    output logic [DCT_FRAME_W-1:0] frame_data,
    input  logic                   frame_ready,
    output logic                   overflow,
    input  logic                   clr_overflow
);

    dct_state_e             r_state;
    dct_state_e             w_state_nxt;
    logic [DCT_BUF_W-1:0]   r_buf;
    logic [DCT_BUF_W-1:0]   w_buf_nxt;
    logic [DCT_CNT_W-1:0]   r_cnt;
    logic [DCT_CNT_W-1:0]   w_cnt_nxt;
    logic                   r_flush_pend;
    logic                   w_pend_nxt;
    logic                   r_ovf;

    logic                   w_slot_free;
    logic                   w_full;
    logic                   w_nonempty;
    logic                   w_emit;
    logic                   w_acc;
    logic                   w_drop;
    logic                   w_last;

    assign w_full     = (r_state == ST_FULL);
    assign w_nonempty = (r_state != ST_EMPTY);
    assign w_last     = (r_cnt == DCT_CNT_LAST);

    assign w_emit = w_slot_free
                 && (w_full || (r_flush_pend && w_nonempty));
    assign w_acc  = trc_on && atom_valid && (!w_full || w_emit);
    assign w_drop = trc_on && atom_valid && !w_acc;

    assign dct_buffer = r_buf;
    assign dct_count  = r_cnt;
    assign overflow   = r_ovf;

    cpuori_oci_dct_outreg u_outreg (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_emit),
        .i_data      (pack_dct_frame(r_cnt, r_buf)),
        .i_ready     (frame_ready),
        .o_valid     (frame_valid),
        .o_data      (frame_data),
        .o_slot_free (w_slot_free)
    );

    // Fill-level state: empty, filling, or full awaiting a slot.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_EMPTY: begin
                if (w_acc) w_state_nxt = ST_FILL;
            end
            ST_FILL: begin
                if (w_emit)
                    w_state_nxt = w_acc ? ST_FILL : ST_EMPTY;
                else if (w_acc && w_last)
                    w_state_nxt = ST_FULL;
            end
            ST_FULL: begin
                if (w_emit)
                    w_state_nxt = w_acc ? ST_FILL : ST_EMPTY;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Buffer, count and flush request for the next cycle.
    always_comb begin
        w_buf_nxt  = r_buf;
        w_cnt_nxt  = r_cnt;
        w_pend_nxt = r_flush_pend;
        if (w_emit) begin
            w_buf_nxt  = '0;
            w_cnt_nxt  = '0;
            w_pend_nxt = flush && w_acc;
            if (w_acc) begin
                w_buf_nxt[DCT_ATOM_W-1:0] = atom;
                w_cnt_nxt = DCT_CNT_W'(1);
            end
        end else begin
            if (w_acc) begin
                w_buf_nxt = {r_buf[DCT_BUF_W-DCT_ATOM_W-1:0], atom};
                w_cnt_nxt = r_cnt + DCT_CNT_W'(1);
            end
            if (flush && (w_nonempty || w_acc))
                w_pend_nxt = 1'b1;
        end
    end

    // Packer state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_EMPTY;
            r_buf        <= '0;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_buf        <= w_buf_nxt;
            r_cnt        <= w_cnt_nxt;
            r_flush_pend <= w_pend_nxt;
        end
    end

    // Sticky drop flag; a drop beats a concurrent clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_ovf <= 1'b0;
        else if (w_drop)
            r_ovf <= 1'b1;
        else if (clr_overflow)
            r_ovf <= 1'b0;
    end

endmodule
